// File: rtl/img_filter_pkg.sv
// Shared constants and register-set type for the per-pixel colour filter.
// Offsets are carried at the widest supported channel width and zero-extended.
package img_filter_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 32;

    localparam int unsigned ADDR_OFFSET = 32'h000;
    localparam int unsigned ADDR_CTRL   = 32'h004;

    localparam int unsigned CTRL_BYPASS_BIT = 0;
    localparam int unsigned CTRL_INVERT_BIT = 1;

    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] offset;
        logic                      bypass;
        logic                      invert;
    } filter_cfg_t;

endpackage

// File: rtl/img_pixel_filter_if.sv
// Write-only APB bus into the pixel filter register slave.
interface img_pixel_filter_if #(
    parameter int unsigned ADDR_WIDTH = 10
);

    logic [ADDR_WIDTH-1:0] i_apb_paddr;
    logic                  i_apb_psel;
    logic                  i_apb_penable;
    logic                  i_apb_pwrite;
    logic [31:0]           i_apb_pwdata;

    modport master (
        output i_apb_paddr,
        output i_apb_psel,
        output i_apb_penable,
        output i_apb_pwrite,
        output i_apb_pwdata
    );

    modport slave (
        input i_apb_paddr,
        input i_apb_psel,
        input i_apb_penable,
        input i_apb_pwrite,
        input i_apb_pwdata
    );

endinterface

// File: rtl/img_filter_channel.sv
// One colour channel: stage 1 optional inversion, stage 2 saturating offset add.
// Settings travel with the pixel so a frame-boundary update never splits a pixel.
module img_filter_channel
    import img_filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn_apb,
    input  logic                  de_i,
    input  logic [DATA_WIDTH-1:0] px_i,
    input  filter_cfg_t           cfg_i,
    output logic [DATA_WIDTH-1:0] px_o
);

    localparam int unsigned SUM_W = MAX_DATA_WIDTH + 1;

    logic [DATA_WIDTH-1:0]     s1_px_q;
    logic [DATA_WIDTH-1:0]     s1_px_d;
    logic                      s1_de_q;
    logic                      s1_bypass_q;
    logic [MAX_DATA_WIDTH-1:0] s1_offset_q;
    logic [SUM_W-1:0]          sum_c;
    logic [DATA_WIDTH-1:0]     px_d;

    always_comb begin
        s1_px_d = px_i;
        if (!cfg_i.bypass && cfg_i.invert) begin
            s1_px_d = ~px_i;
        end
    end

    // Any carry at or above DATA_WIDTH means the channel saturates.
    always_comb begin
        sum_c = SUM_W'(s1_px_q) + SUM_W'(s1_offset_q);
        px_d  = '0;
        if (s1_bypass_q) begin
            px_d = s1_px_q;
        end else if (s1_de_q) begin
            px_d = (|sum_c[SUM_W-1:DATA_WIDTH]) ? '1 : sum_c[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rstn_apb) begin
        if (rstn_apb) begin
            s1_px_q     <= '0;
            s1_de_q     <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_offset_q <= '0;
            px_o        <= '0;
        end else begin
            s1_px_q     <= s1_px_d;
            s1_de_q     <= de_i;
            s1_bypass_q <= cfg_i.bypass;
            s1_offset_q <= cfg_i.offset;
            px_o        <= px_d;
        end
    end

endmodule

// File: rtl/img_pixel_filter.sv
// Per-pixel colour filter: APB register decode, frame-synchronous shadow
// registers, three channel pipelines and a matching 2-cycle sync delay line.
module img_pixel_filter
    import img_filter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn_apb,
    img_pixel_filter_if.slave     apb,
    input  logic                  i_vs,
    input  logic                  i_hs,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_r,
    input  logic [DATA_WIDTH-1:0] i_g,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_vs,
    output logic                  o_hs,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_r,
    output logic [DATA_WIDTH-1:0] o_g,
    output logic [DATA_WIDTH-1:0] o_b
);

    logic        apb_wr_c;
    logic        vs_rise_c;
    logic        vs_prev_q;
    filter_cfg_t prog_q;
    filter_cfg_t prog_d;
    filter_cfg_t act_q;
    filter_cfg_t act_d;
    logic [2:0]  sync_s1_q;
    logic [2:0]  sync_s2_q;
    logic        unused_apb;

    assign apb_wr_c   = apb.i_apb_psel & apb.i_apb_penable & apb.i_apb_pwrite;
    assign vs_rise_c  = i_vs & ~vs_prev_q;
    assign unused_apb = ^apb.i_apb_pwdata;

    always_comb begin
        prog_d = prog_q;
        if (apb_wr_c) begin
            if (apb.i_apb_paddr == ADDR_WIDTH'(ADDR_OFFSET)) begin
                prog_d.offset = MAX_DATA_WIDTH'(apb.i_apb_pwdata[DATA_WIDTH-1:0]);
            end else if (apb.i_apb_paddr == ADDR_WIDTH'(ADDR_CTRL)) begin
                prog_d.bypass = apb.i_apb_pwdata[CTRL_BYPASS_BIT];
                prog_d.invert = apb.i_apb_pwdata[CTRL_INVERT_BIT];
            end
        end
    end

    // The pixel arriving on the vs rising-edge cycle already sees the new set,
    // and a write landing on that same edge only reaches the next frame.
    always_comb begin
        act_d = act_q;
        if (vs_rise_c) begin
            act_d = prog_q;
        end
    end

    always_ff @(posedge clk or posedge rstn_apb) begin
        if (rstn_apb) begin
            prog_q    <= '0;
            act_q     <= '0;
            vs_prev_q <= 1'b0;
            sync_s1_q <= '0;
            sync_s2_q <= '0;
        end else begin
            prog_q    <= prog_d;
            act_q     <= act_d;
            vs_prev_q <= i_vs;
            sync_s1_q <= {i_vs, i_hs, i_de};
            sync_s2_q <= sync_s1_q;
        end
    end

    assign {o_vs, o_hs, o_de} = sync_s2_q;

    img_filter_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch_r (
        .clk      (clk),
        .rstn_apb (rstn_apb),
        .de_i     (i_de),
        .px_i     (i_r),
        .cfg_i    (act_d),
        .px_o     (o_r)
    );

    img_filter_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch_g (
        .clk      (clk),
        .rstn_apb (rstn_apb),
        .de_i     (i_de),
        .px_i     (i_g),
        .cfg_i    (act_d),
        .px_o     (o_g)
    );

    img_filter_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch_b (
        .clk      (clk),
        .rstn_apb (rstn_apb),
        .de_i     (i_de),
        .px_i     (i_b),
        .cfg_i    (act_d),
        .px_o     (o_b)
    );

endmodule

// File: tb/tb_img_pixel_filter.sv
// Self-checking bench for img_pixel_filter: directed vector table, hand-written
// frame-boundary sequences and a randomized run against a reference model.
module tb_img_pixel_filter;

    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 8;
    localparam int          MAXV = 255;

    logic          clk = 1'b0;
    logic          rstn_apb;
    logic          vs, hs, de;
    logic [DW-1:0] r, g, b;
    logic          o_vs, o_hs, o_de;
    logic [DW-1:0] o_r, o_g, o_b;

    img_pixel_filter_if #(.ADDR_WIDTH(AW)) apb_bus ();

    img_pixel_filter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rstn_apb (rstn_apb),
        .apb      (apb_bus),
        .i_vs     (vs),
        .i_hs     (hs),
        .i_de     (de),
        .i_r      (r),
        .i_g      (g),
        .i_b      (b),
        .o_vs     (o_vs),
        .o_hs     (o_hs),
        .o_de     (o_de),
        .o_r      (o_r),
        .o_g      (o_g),
        .o_b      (o_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: programmed / active registers and the vs history.
    int          m_prog_off, m_act_off;
    bit          m_prog_byp, m_prog_inv, m_act_byp, m_act_inv, m_prev_vs;
    logic [26:0] m_pend, m_exp;

    typedef struct {
        int offset;
        int ctrl;
        bit de;
        int r, g, b;
        int er, eg, eb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_ch(input int x, input int off, input bit byp, input bit inv, input bit d);
        int y;
        if (byp) return x;
        if (!d) return 0;
        y = inv ? (MAXV - x) : x;
        return (y + off > MAXV) ? MAXV : (y + off);
    endfunction

    task automatic model_reset();
        m_prog_off = 0; m_act_off = 0;
        m_prog_byp = 0; m_prog_inv = 0;
        m_act_byp  = 0; m_act_inv  = 0;
        m_prev_vs  = 0;
        m_pend = '0;
        m_exp  = '0;
    endtask

    // One clock: model what the DUT sampled, then compare after the edge.
    task automatic tick(input string name);
        bit wr, rise;
        int eoff;
        bit ebyp, einv;
        @(posedge clk);
        if (rstn_apb) begin
            model_reset();
        end else begin
            wr   = apb_bus.i_apb_psel && apb_bus.i_apb_penable && apb_bus.i_apb_pwrite;
            rise = vs && !m_prev_vs;
            eoff = rise ? m_prog_off : m_act_off;
            ebyp = rise ? m_prog_byp : m_act_byp;
            einv = rise ? m_prog_inv : m_act_inv;
            m_exp  = m_pend;
            m_pend = {vs, hs, de,
                      8'(ref_ch(int'(r), eoff, ebyp, einv, de)),
                      8'(ref_ch(int'(g), eoff, ebyp, einv, de)),
                      8'(ref_ch(int'(b), eoff, ebyp, einv, de))};
            if (rise) begin
                m_act_off = m_prog_off; m_act_byp = m_prog_byp; m_act_inv = m_prog_inv;
            end
            if (wr) begin
                if (apb_bus.i_apb_paddr == AW'(0)) begin
                    m_prog_off = int'(apb_bus.i_apb_pwdata[7:0]);
                end else if (apb_bus.i_apb_paddr == AW'(4)) begin
                    m_prog_byp = apb_bus.i_apb_pwdata[0];
                    m_prog_inv = apb_bus.i_apb_pwdata[1];
                end
            end
            m_prev_vs = vs;
        end
        #1;
        chk(name, 64'({o_vs, o_hs, o_de, o_r, o_g, o_b}), 64'(m_exp));
        @(negedge clk);
    endtask

    task automatic set_idle();
        vs = 0; hs = 0; de = 0; r = '0; g = '0; b = '0;
        apb_bus.i_apb_psel    = 0;
        apb_bus.i_apb_penable = 0;
        apb_bus.i_apb_pwrite  = 0;
        apb_bus.i_apb_paddr   = '0;
        apb_bus.i_apb_pwdata  = '0;
    endtask

    task automatic apb_write(input int addr, input int data);
        apb_bus.i_apb_psel    = 1;
        apb_bus.i_apb_penable = 0;
        apb_bus.i_apb_pwrite  = 1;
        apb_bus.i_apb_paddr   = AW'(addr);
        apb_bus.i_apb_pwdata  = 32'(data);
        tick("apb_setup");
        apb_bus.i_apb_penable = 1;
        tick("apb_access");
        set_idle();
    endtask

    // Present one pixel (optionally on a vs rising edge), then return its result.
    task automatic send_px(input bit vsv, input bit dev, input int rv, input int gv, input int bv,
                           output logic [24:0] res);
        vs = vsv; de = dev; r = DW'(rv); g = DW'(gv); b = DW'(bv);
        tick("px_in");
        set_idle();
        tick("px_out");
        res = {o_de, o_r, o_g, o_b};
    endtask

    task automatic rand_inputs();
        vs = 1'($urandom); hs = 1'($urandom); de = 1'($urandom);
        r = DW'($urandom); g = DW'($urandom); b = DW'($urandom);
    endtask

    logic [24:0] res;

    initial begin
        vecs[0] = '{0,   0, 1, 40, 80, 120, 40, 80, 120};
        vecs[1] = '{10,  0, 1, 100, 0, 245, 110, 10, 255};
        vecs[2] = '{0,   2, 1, 30, 0, 255, 225, 255, 0};
        vecs[3] = '{10,  2, 1, 30, 250, 255, 235, 15, 10};
        vecs[4] = '{10,  1, 0, 200, 7, 0, 200, 7, 0};
        vecs[5] = '{50,  0, 0, 1, 2, 3, 0, 0, 0};
        vecs[6] = '{255, 0, 1, 0, 1, 255, 255, 255, 255};
        vecs[7] = '{0,   3, 1, 200, 9, 17, 200, 9, 17};

        set_idle();
        model_reset();
        rstn_apb = 1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick("reset_hold");
        end
        set_idle();
        rstn_apb = 0;
        tick("reset_release");

        // Reset register values pass the pixel through unchanged.
        send_px(0, 1, 40, 80, 120, res);
        chk("post_reset_px", 64'(res), 64'({1'b1, 8'd40, 8'd80, 8'd120}));

        for (int i = 0; i < 8; i++) begin
            apb_write(0, vecs[i].offset);
            apb_write(4, vecs[i].ctrl);
            send_px(1, vecs[i].de, vecs[i].r, vecs[i].g, vecs[i].b, res);
            chk($sformatf("vec%0d", i), 64'(res),
                64'({vecs[i].de, 8'(vecs[i].er), 8'(vecs[i].eg), 8'(vecs[i].eb)}));
        end

        // Mid-frame write is held back until the next vs rising edge.
        apb_write(4, 0);
        apb_write(0, 10);
        send_px(1, 1, 100, 0, 0, res);
        chk("frame_off10", 64'(res[23:16]), 64'(110));
        apb_write(0, 20);
        send_px(0, 1, 100, 0, 0, res);
        chk("midframe_still10", 64'(res[23:16]), 64'(110));
        send_px(1, 1, 100, 0, 0, res);
        chk("next_frame_off20", 64'(res[23:16]), 64'(120));

        // Write accepted on the vs rising-edge cycle only applies next frame.
        apb_bus.i_apb_psel   = 1;
        apb_bus.i_apb_pwrite = 1;
        apb_bus.i_apb_paddr  = AW'(0);
        apb_bus.i_apb_pwdata = 32'(30);
        tick("simul_setup");
        apb_bus.i_apb_penable = 1;
        vs = 1; de = 1; r = DW'(100);
        tick("simul_access");
        set_idle();
        tick("simul_out");
        chk("simul_old_value", 64'(o_r), 64'(120));
        send_px(1, 1, 100, 0, 0, res);
        chk("simul_next_frame", 64'(res[23:16]), 64'(130));

        // Unmapped address and read access leave the settings alone.
        apb_write(8, 255);
        apb_bus.i_apb_psel = 1; apb_bus.i_apb_paddr = AW'(0); apb_bus.i_apb_pwdata = 32'(0);
        tick("read_setup");
        apb_bus.i_apb_penable = 1;
        tick("read_access");
        set_idle();
        send_px(1, 1, 100, 0, 0, res);
        chk("bad_addr_ignored", 64'(res[23:16]), 64'(130));

        // Asynchronous reset mid-frame clears outputs before any clock edge.
        vs = 0; hs = 1; de = 1; r = DW'(55); g = DW'(66); b = DW'(77);
        tick("pre_reset");
        rstn_apb = 1;
        #1;
        chk("async_reset_out", 64'({o_vs, o_hs, o_de, o_r, o_g, o_b}), 64'(0));
        model_reset();
        rand_inputs();
        tick("reset_mid");
        set_idle();
        @(negedge clk);
        rstn_apb = 0;
        send_px(1, 1, 40, 80, 120, res);
        chk("reset_regs_cleared", 64'(res), 64'({1'b1, 8'd40, 8'd80, 8'd120}));

        // Randomized traffic with occasional APB writes and one reset pulse.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            vs = ($urandom_range(0, 5) == 0);
            apb_bus.i_apb_psel    = 0;
            apb_bus.i_apb_penable = 0;
            apb_bus.i_apb_pwrite  = 0;
            if ($urandom_range(0, 4) == 0) begin
                apb_bus.i_apb_psel    = 1;
                apb_bus.i_apb_penable = 1;
                apb_bus.i_apb_pwrite  = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       apb_bus.i_apb_paddr = AW'(0);
                    1:       apb_bus.i_apb_paddr = AW'(4);
                    2:       apb_bus.i_apb_paddr = AW'(8);
                    default: apb_bus.i_apb_paddr = AW'($urandom);
                endcase
                apb_bus.i_apb_pwdata = $urandom;
            end
            rstn_apb = (i == 300);
            tick("random");
        end
        rstn_apb = 0;
        set_idle();
        tick("drain0");
        tick("drain1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_pixel_filter.md
# img_pixel_filter

Per-pixel colour filter with a write-only APB register slave. It sits between the video source (vs/hs/de + RGB stream) and the video sink. It applies optional inversion, then a saturating brightness offset, to each of the R, G and B channels. Control registers are programmed over APB and take effect at frame boundaries.

## Interface
- ADDR_WIDTH, 10, APB address width (max 32)
- DATA_WIDTH, 8, colour channel width (8/16/32)

- clk  in  1  single clock for the APB slave and the video path; APB signals are synchronous to clk
- rstn_apb  in  1  reset rstn_apb, asynchronous, active-high; clock clk
- i_apb_paddr  in  ADDR_WIDTH  APB byte address
- i_apb_psel  in  1  APB select
- i_apb_penable  in  1  APB enable (access phase)
- i_apb_pwrite  in  1  APB direction, 1 = write
- i_apb_pwdata  in  32  APB write data
- i_vs  in  1  vertical sync, active-high
- i_hs  in  1  horizontal sync, active-high
- i_de  in  1  data enable
- i_r, i_g, i_b  in  DATA_WIDTH each  input pixel
- o_vs, o_hs, o_de  out  1 each  delayed syncs
- o_r, o_g, o_b  out  DATA_WIDTH each  filtered pixel

## Operation
- APB write is accepted on any clk edge where psel & penable & pwrite = 1.
  - No wait states; no PREADY or PRDATA.
  - Reads are ignored.
- Register map (byte addresses):
  - 0x000 OFFSET: wdata[DATA_WIDTH-1:0], unsigned brightness offset.
  - 0x004 CTRL: bit0 BYPASS, bit1 INVERT; other bits are ignored.
  - Writes to any other address are discarded.
- Shadow registers:
  - Each register has an active copy.
  - The active copy loads from the programmed copy on the rising edge of i_vs, i.e. the cycle where i_vs = 1 and the registered previous i_vs = 0.
  - Writes mid-frame do not affect the current frame.
- Per channel x, using the active registers:
  - BYPASS = 1: output = x, unmodified.
  - Otherwise, stage 1: y = INVERT ? (2^DATA_WIDTH−1 − x) : x.
  - Stage 2: z = min(y + OFFSET, 2^DATA_WIDTH−1). Compute the sum at DATA_WIDTH+1 bits, then clamp.
  - When the delayed de = 0 and BYPASS = 0, o_r/o_g/o_b = 0.
- All three channels use identical settings.

## Timing
- Reset (rstn_apb = 1, asynchronous):
  - All outputs 0.
  - Programmed and active OFFSET and CTRL = 0.
  - Previous-vs register = 0.
- Latency is exactly 2 clk cycles from i_* to o_*, for data and for vs/hs/de alike.
  - Alignment is preserved in all modes, including bypass.
- Register-to-pixel timing:
  - A programmed value becomes visible 1 cycle after the write-accept edge.
  - It is copied to the active set on the vs rising-edge cycle.
  - Pixels entering on that same cycle or later use the new value.
- Simultaneous APB write and vs rising edge: the active copy takes the old programmed value. The new value applies from the next frame.
- Reset asserted mid-frame: the pipeline flushes to 0 immediately. Outputs resume 2 cycles after deassertion with reset register values.
- Back-to-back APB writes are accepted every cycle the access-phase condition holds.

## Structure
- Package img_filter_pkg:
  - ADDR_OFFSET = 0x000, ADDR_CTRL = 0x004.
  - CTRL_BYPASS_BIT = 0, CTRL_INVERT_BIT = 1.
  - typedef struct for the active register set (offset, bypass, invert).
- Sub-module img_filter_channel:
  - 2-stage invert + saturating-add pipeline for one channel, parameterised by DATA_WIDTH.
  - Instantiated three times (R, G, B).
- The top level holds the APB decode, the shadow registers, the vs edge detect and the sync delay line.

## Test plan
- Assert rstn_apb = 1 with random inputs -> all outputs 0. After deassertion with OFFSET/CTRL untouched, pixel (40,80,120) with de = 1 -> (40,80,120) two cycles later.
- Write OFFSET = 10 at 0x000, raise i_vs, send r = 100, g = 0, b = 245 with de = 1 -> o_r = 110, o_g = 10, o_b = 255 (saturated), 2 cycles later.
- Write CTRL = 0x2, OFFSET = 0, then vs edge, pixel r = 30 -> o_r = 225. With OFFSET = 10 -> o_r = 235.
- With OFFSET = 10 active, write OFFSET = 20 mid-frame:
  - Current frame still adds 10.
  - After the next vs rising edge, the same pixel r = 100 -> 120.
- Write CTRL = 0x1, then vs edge, pixel 200 with de = 0 -> o_r = 200, delayed exactly 2 cycles, with o_de = 0 aligned.
- Write 0xFF to 0x008, then vs edge -> behaviour unchanged from prior settings; delayed o_vs/o_hs/o_de equal inputs shifted 2 cycles throughout.
